// File: rtl/sr_latch_checker.sv
// ---------------------------------------------------------------------------
// sr_latch_checker
//
// Clocked response monitor for one SR latch (NAND or NOR flavour). It samples
// the raw S/R drive and the observed Q/Qbar, tracks the latch state in a
// small reference model, and compares the observed outputs against it once
// the inputs have been stable for SETTLE_CYCLES clocks. Set, reset,
// forbidden, race and mismatch events are counted in saturating counters.
//
// Parameters:
//   ACTIVE_LOW    1 = NAND latch (active-low inputs, forbidden outputs 11)
//                 0 = NOR latch  (active-high inputs, forbidden outputs 00)
//   SETTLE_CYCLES clocks to wait after an input-pair change (0..15)
//   CNT_W         width of every event/error counter
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   s_in, r_in    latch inputs exactly as driven to the latch
//   q_in, qbar_in observed latch outputs
//   clr           synchronous clear of counters, err_sticky and capture
//   exp_q         model's expected Q (0 unless exp_valid)
//   exp_valid     model is in Q0 or Q1
//   err           one-cycle pulse per mismatching compare
//   err_sticky    set by err, cleared by rst or clr
//   set_cnt, reset_cnt, forb_cnt, race_cnt, err_cnt   event counters
//
// Optional feature (macro SR_CHK_ERR_CAPTURE_EN):
//   cap_valid, cap_pair, cap_q, cap_state hold the pair, observed {q,qbar}
//   and model state of the first mismatch since the last rst/clr.
// ---------------------------------------------------------------------------
module sr_latch_checker #(
    parameter int ACTIVE_LOW    = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             r_in,
    input  logic             q_in,
    input  logic             qbar_in,
    input  logic             clr,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] reset_cnt,
    output logic [CNT_W-1:0] forb_cnt,
    output logic [CNT_W-1:0] race_cnt,
`ifdef SR_CHK_ERR_CAPTURE_EN
    output logic             cap_valid,
    output logic [1:0]       cap_pair,
    output logic [1:0]       cap_q,
    output logic [1:0]       cap_state,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    // Model state encoding
    localparam logic [1:0] ST_UNK  = 2'b00;
    localparam logic [1:0] ST_Q0   = 2'b01;
    localparam logic [1:0] ST_Q1   = 2'b10;
    localparam logic [1:0] ST_FORB = 2'b11;

    localparam logic             POL         = (ACTIVE_LOW != 0);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam int               N_CNT       = 5;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Counter slots
    localparam int C_SET  = 0;
    localparam int C_RST  = 1;
    localparam int C_FORB = 2;
    localparam int C_RACE = 3;
    localparam int C_ERR  = 4;

    logic [1:0]       pair;
    logic [1:0]       prev_pair_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       settle_q;
    logic [3:0]       settle_d;
    logic             pair_chg;
    logic             cmp_en;
    logic [1:0]       exp_pat;
    logic [1:0]       obs;
    logic             mismatch;
    logic             err_q;
    logic             err_sticky_q;
    logic [N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];

    // Normalised pair: bit 1 = set active, bit 0 = reset active
    assign pair     = {s_in ^ POL, r_in ^ POL};
    assign pair_chg = (pair != prev_pair_q);
    assign obs      = {q_in, qbar_in};

    // Model next state
    always_comb begin
        state_d = state_q;
        case (pair)
            2'b10:   state_d = ST_Q1;
            2'b01:   state_d = ST_Q0;
            2'b11:   state_d = ST_FORB;
            default: begin
                // Simultaneous release from forbidden: outcome is a race
                if (state_q == ST_FORB) begin
                    state_d = ST_UNK;
                end
            end
        endcase
    end

    // Settle window: reload on every pair change, otherwise run down to 0
    always_comb begin
        settle_d = settle_q;
        if (pair_chg) begin
            settle_d = SETTLE_INIT;
        end else if (settle_q != 4'd0) begin
            settle_d = settle_q - 4'd1;
        end
    end

    // The compare looks at the state/settle values being written this cycle,
    // so SETTLE_CYCLES=0 checks the new state in the cycle it is entered.
    always_comb begin
        exp_pat = {POL, POL};
        case (state_d)
            ST_Q1:   exp_pat = 2'b10;
            ST_Q0:   exp_pat = 2'b01;
            default: exp_pat = {POL, POL};
        endcase
    end

    assign cmp_en   = (settle_d == 4'd0) && (state_d != ST_UNK);
    assign mismatch = cmp_en && (obs != exp_pat);

    assign cnt_inc[C_SET]  = pair_chg && (pair == 2'b10);
    assign cnt_inc[C_RST]  = pair_chg && (pair == 2'b01);
    assign cnt_inc[C_FORB] = pair_chg && (pair == 2'b11);
    assign cnt_inc[C_RACE] = (prev_pair_q == 2'b11) && (pair == 2'b00);
    assign cnt_inc[C_ERR]  = mismatch;

    // Saturating counters; clr wins over a same-cycle increment
    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            assign cnt_d[gi] = clr ? '0 :
                               (cnt_inc[gi] && (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + CNT_ONE :
                               cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pair_q  <= 2'b00;
            state_q      <= ST_UNK;
            settle_q     <= 4'd0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            prev_pair_q <= pair;
            state_q     <= state_d;
            settle_q    <= settle_d;
            err_q       <= mismatch;
            if (clr) begin
                err_sticky_q <= 1'b0;
            end else if (mismatch) begin
                err_sticky_q <= 1'b1;
            end
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SR_CHK_ERR_CAPTURE_EN
    logic       cap_valid_q;
    logic [1:0] cap_pair_q;
    logic [1:0] cap_q_q;
    logic [1:0] cap_state_q;

    // Only the first mismatch after rst/clr is kept
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cap_valid_q <= 1'b0;
            cap_pair_q  <= 2'b00;
            cap_q_q     <= 2'b00;
            cap_state_q <= 2'b00;
        end else if (mismatch && !cap_valid_q) begin
            cap_valid_q <= 1'b1;
            cap_pair_q  <= pair;
            cap_q_q     <= obs;
            cap_state_q <= state_d;
        end
    end

    assign cap_valid = cap_valid_q;
    assign cap_pair  = cap_pair_q;
    assign cap_q     = cap_q_q;
    assign cap_state = cap_state_q;
`endif

    assign exp_valid  = (state_q == ST_Q0) || (state_q == ST_Q1);
    assign exp_q      = (state_q == ST_Q1);
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign set_cnt    = cnt_q[C_SET];
    assign reset_cnt  = cnt_q[C_RST];
    assign forb_cnt   = cnt_q[C_FORB];
    assign race_cnt   = cnt_q[C_RACE];
    assign err_cnt    = cnt_q[C_ERR];

endmodule

// File: tb/tb_sr_latch_checker.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_checker
//
// Three checker instances: A (NAND, settle 2, 8-bit counters), B (NAND,
// settle 2, 2-bit counters) and C (NOR, settle 0). Directed stimulus pushes
// hand-computed expectations, tagged with the cycle they apply to, into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_sr_latch_checker;

    localparam int IA = 0;
    localparam int IB = 1;
    localparam int IC = 2;

    localparam int F_EXPQ   = 0;
    localparam int F_EXPV   = 1;
    localparam int F_ERR    = 2;
    localparam int F_STICKY = 3;
    localparam int F_SET    = 4;
    localparam int F_RST    = 5;
    localparam int F_FORB   = 6;
    localparam int F_RACE   = 7;
    localparam int F_ERRCNT = 8;
    localparam int F_CAPV   = 9;
    localparam int F_CAPP   = 10;
    localparam int F_CAPQ   = 11;
    localparam int F_CAPS   = 12;

    typedef struct {
        int    cyc;
        int    inst;
        int    fld;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t keep[$];

    // Instance A
    logic rst_a, s_a, r_a, q_a, qb_a, clr_a;
    logic eq_a, ev_a, err_a, st_a;
    logic [7:0] set_a, rc_a, fc_a, race_a, ec_a;
    // Instance B
    logic rst_b, s_b, r_b, q_b, qb_b, clr_b;
    logic eq_b, ev_b, err_b, st_b;
    logic [1:0] set_b, rc_b, fc_b, race_b, ec_b;
    // Instance C
    logic rst_c, s_c, r_c, q_c, qb_c, clr_c;
    logic eq_c, ev_c, err_c, st_c;
    logic [7:0] set_c, rc_c, fc_c, race_c, ec_c;
`ifdef SR_CHK_ERR_CAPTURE_EN
    logic       cv_a, cv_b, cv_c;
    logic [1:0] cp_a, cq_a, cs_a, cp_b, cq_b, cs_b, cp_c, cq_c, cs_c;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_latch_checker #(.ACTIVE_LOW(1), .SETTLE_CYCLES(2), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst_a), .s_in(s_a), .r_in(r_a), .q_in(q_a), .qbar_in(qb_a),
        .clr(clr_a), .exp_q(eq_a), .exp_valid(ev_a), .err(err_a), .err_sticky(st_a),
        .set_cnt(set_a), .reset_cnt(rc_a), .forb_cnt(fc_a), .race_cnt(race_a),
`ifdef SR_CHK_ERR_CAPTURE_EN
        .cap_valid(cv_a), .cap_pair(cp_a), .cap_q(cq_a), .cap_state(cs_a),
`endif
        .err_cnt(ec_a)
    );

    sr_latch_checker #(.ACTIVE_LOW(1), .SETTLE_CYCLES(2), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst_b), .s_in(s_b), .r_in(r_b), .q_in(q_b), .qbar_in(qb_b),
        .clr(clr_b), .exp_q(eq_b), .exp_valid(ev_b), .err(err_b), .err_sticky(st_b),
        .set_cnt(set_b), .reset_cnt(rc_b), .forb_cnt(fc_b), .race_cnt(race_b),
`ifdef SR_CHK_ERR_CAPTURE_EN
        .cap_valid(cv_b), .cap_pair(cp_b), .cap_q(cq_b), .cap_state(cs_b),
`endif
        .err_cnt(ec_b)
    );

    sr_latch_checker #(.ACTIVE_LOW(0), .SETTLE_CYCLES(0), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst_c), .s_in(s_c), .r_in(r_c), .q_in(q_c), .qbar_in(qb_c),
        .clr(clr_c), .exp_q(eq_c), .exp_valid(ev_c), .err(err_c), .err_sticky(st_c),
        .set_cnt(set_c), .reset_cnt(rc_c), .forb_cnt(fc_c), .race_cnt(race_c),
`ifdef SR_CHK_ERR_CAPTURE_EN
        .cap_valid(cv_c), .cap_pair(cp_c), .cap_q(cq_c), .cap_state(cs_c),
`endif
        .err_cnt(ec_c)
    );

    function automatic int get_act(int inst, int fld);
        int r;
        r = -1;
        if (inst == IA) begin
            case (fld)
                F_EXPQ: r = int'(eq_a);    F_EXPV: r = int'(ev_a);
                F_ERR: r = int'(err_a);    F_STICKY: r = int'(st_a);
                F_SET: r = int'(set_a);    F_RST: r = int'(rc_a);
                F_FORB: r = int'(fc_a);    F_RACE: r = int'(race_a);
                F_ERRCNT: r = int'(ec_a);
                default: r = -1;
            endcase
        end else if (inst == IB) begin
            case (fld)
                F_EXPQ: r = int'(eq_b);    F_EXPV: r = int'(ev_b);
                F_ERR: r = int'(err_b);    F_STICKY: r = int'(st_b);
                F_SET: r = int'(set_b);    F_RST: r = int'(rc_b);
                F_FORB: r = int'(fc_b);    F_RACE: r = int'(race_b);
                F_ERRCNT: r = int'(ec_b);
                default: r = -1;
            endcase
        end else begin
            case (fld)
                F_EXPQ: r = int'(eq_c);    F_EXPV: r = int'(ev_c);
                F_ERR: r = int'(err_c);    F_STICKY: r = int'(st_c);
                F_SET: r = int'(set_c);    F_RST: r = int'(rc_c);
                F_FORB: r = int'(fc_c);    F_RACE: r = int'(race_c);
                F_ERRCNT: r = int'(ec_c);
`ifdef SR_CHK_ERR_CAPTURE_EN
                F_CAPV: r = int'(cv_c);    F_CAPP: r = int'(cp_c);
                F_CAPQ: r = int'(cq_c);    F_CAPS: r = int'(cs_c);
`endif
                default: r = -1;
            endcase
        end
        return r;
    endfunction

    // Monitor: compare every expectation due this cycle
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc <= cyc) begin
                int act;
                act = get_act(sb[i].inst, sb[i].fld);
                checks++;
                if (sb[i].cyc < cyc) begin
                    failures++;
                    $display("FAIL %s: stale expectation for cycle %0d seen at %0d", sb[i].name, sb[i].cyc, cyc);
                end else if (act != sb[i].val) begin
                    failures++;
                    $display("FAIL %s: cycle %0d got %0d expected %0d", sb[i].name, cyc, act, sb[i].val);
                end else begin
                    $display("ok   %s: cycle %0d value %0d", sb[i].name, cyc, act);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    // Expect value 'val' on field 'fld' of instance 'inst' after 'd' more edges
    task automatic ex(input int d, input int inst, input int fld, input int val, input string nm);
        exp_t e;
        e.cyc = cyc + d; e.inst = inst; e.fld = fld; e.val = val; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        clr_a = 0; clr_b = 0; clr_c = 0;
        s_a = 1; r_a = 1; q_a = 0; qb_a = 0;     // NAND inactive
        s_b = 1; r_b = 1; q_b = 0; qb_b = 0;
        s_c = 0; r_c = 0; q_c = 0; qb_c = 0;     // NOR inactive
        for (int f = F_EXPQ; f <= F_ERRCNT; f++) begin
            ex(1, IA, f, 0, "a_reset");
            ex(1, IC, f, 0, "c_reset");
        end
        step(2);
        rst_a = 0; rst_b = 0; rst_c = 0;
        step(1);

        // ---- A: set then reset (NAND) ----
        s_a = 0; r_a = 1; q_a = 1; qb_a = 0;
        ex(1, IA, F_SET, 1, "a_set_cnt"); ex(1, IA, F_EXPQ, 1, "a_set_expq");
        ex(1, IA, F_EXPV, 1, "a_set_expv"); ex(5, IA, F_SET, 1, "a_set_hold");
        for (int d = 1; d <= 5; d++) ex(d, IA, F_ERR, 0, "a_set_err");
        step(5);
        s_a = 1; r_a = 0; q_a = 0; qb_a = 1;
        ex(1, IA, F_RST, 1, "a_rst_cnt"); ex(1, IA, F_EXPQ, 0, "a_rst_expq");
        ex(1, IA, F_EXPV, 1, "a_rst_expv");
        for (int d = 1; d <= 5; d++) ex(d, IA, F_ERR, 0, "a_rst_err");
        step(5);

        // ---- A: forbidden, then direct release (race) ----
        s_a = 0; r_a = 0; q_a = 1; qb_a = 1;
        ex(1, IA, F_FORB, 1, "a_forb_cnt"); ex(1, IA, F_EXPV, 0, "a_forb_expv");
        ex(1, IA, F_EXPQ, 0, "a_forb_expq");
        for (int d = 1; d <= 4; d++) ex(d, IA, F_ERR, 0, "a_forb_err");
        step(4);
        s_a = 1; r_a = 1; q_a = 0; qb_a = 0;
        ex(1, IA, F_RACE, 1, "a_race_cnt"); ex(1, IA, F_EXPV, 0, "a_race_expv");
        for (int d = 1; d <= 5; d++) ex(d, IA, F_ERR, 0, "a_unk_err");
        ex(5, IA, F_ERRCNT, 0, "a_unk_errcnt");
        step(5);

        // ---- A: mismatch after settle ----
        s_a = 0; r_a = 1; q_a = 1; qb_a = 0;
        ex(1, IA, F_SET, 2, "a_set2_cnt");
        step(4);
        s_a = 1; r_a = 0;                     // reset, but Q stuck at 1
        ex(1, IA, F_RST, 2, "a_rst2_cnt");
        ex(1, IA, F_ERR, 0, "a_settle1_err"); ex(2, IA, F_ERR, 0, "a_settle2_err");
        ex(2, IA, F_STICKY, 0, "a_settle2_sticky");
        ex(3, IA, F_ERR, 1, "a_mis_err"); ex(3, IA, F_ERRCNT, 1, "a_mis_errcnt1");
        ex(3, IA, F_STICKY, 1, "a_mis_sticky"); ex(4, IA, F_ERRCNT, 2, "a_mis_errcnt2");
        ex(5, IA, F_ERR, 1, "a_mis_err3"); ex(5, IA, F_ERRCNT, 3, "a_mis_errcnt3");
        step(5);
        q_a = 0; qb_a = 1; clr_a = 1;
        ex(1, IA, F_SET, 0, "a_clr_set"); ex(1, IA, F_RST, 0, "a_clr_rst");
        ex(1, IA, F_FORB, 0, "a_clr_forb"); ex(1, IA, F_RACE, 0, "a_clr_race");
        ex(1, IA, F_ERRCNT, 0, "a_clr_errcnt"); ex(1, IA, F_STICKY, 0, "a_clr_sticky");
        ex(1, IA, F_ERR, 0, "a_clr_err"); ex(1, IA, F_EXPV, 1, "a_clr_expv");
        ex(1, IA, F_EXPQ, 0, "a_clr_expq");
        step(1);
        // clr held while a set event arrives: event is lost, model still moves
        s_a = 0; r_a = 1; q_a = 1; qb_a = 0;
        ex(1, IA, F_SET, 0, "a_clrprio_set"); ex(1, IA, F_EXPQ, 1, "a_clrprio_expq");
        step(1);
        clr_a = 0;
        ex(1, IA, F_SET, 0, "a_postclr_set");
        for (int d = 1; d <= 3; d++) ex(d, IA, F_ERR, 0, "a_postclr_err");
        step(3);

        // ---- A: settle reload with wrong outputs ----
        q_a = 0; qb_a = 0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin s_a = 1; r_a = 0; end
            else begin s_a = 0; r_a = 1; end
            ex(1, IA, F_ERR, 0, "a_reload_err");
            step(1);
        end
        q_a = 1; qb_a = 0;
        ex(1, IA, F_SET, 3, "a_toggle_set"); ex(1, IA, F_RST, 3, "a_toggle_rst");
        for (int d = 1; d <= 3; d++) ex(d, IA, F_ERR, 0, "a_toggle_err");
        ex(3, IA, F_ERRCNT, 0, "a_toggle_errcnt");
        step(3);

        // ---- B: saturation with 2-bit counters ----
        for (int i = 0; i < 5; i++) begin
            s_b = 0; r_b = 1; q_b = 1; qb_b = 0;
            if (i == 2) ex(1, IB, F_SET, 3, "b_set_third");
            step(1);
            s_b = 1; r_b = 0; q_b = 0; qb_b = 1;
            step(1);
        end
        s_b = 0; r_b = 1; q_b = 0; qb_b = 1;     // one more set, wrong outputs
        ex(1, IB, F_SET, 3, "b_sat_set"); ex(1, IB, F_RST, 3, "b_sat_rst");
        ex(1, IB, F_ERR, 0, "b_sat_err");
        step(1);
        rst_b = 1;                                 // reset mid-settle
        for (int f = F_EXPQ; f <= F_ERRCNT; f++) ex(1, IB, f, 0, "b_midreset");
        step(1);
        rst_b = 0;
        ex(1, IB, F_SET, 1, "b_after_rst_set");
        ex(1, IB, F_ERR, 0, "b_after_rst_err1"); ex(2, IB, F_ERR, 0, "b_after_rst_err2");
        step(2);
        q_b = 1; qb_b = 0;
        ex(1, IB, F_ERR, 0, "b_fixed_err"); ex(2, IB, F_ERRCNT, 0, "b_fixed_errcnt");
        step(2);

        // ---- C: NOR, settle 0 ----
        s_c = 1; r_c = 0; q_c = 1; qb_c = 0;
        ex(1, IC, F_SET, 1, "c_set_cnt"); ex(1, IC, F_EXPQ, 1, "c_set_expq");
        ex(1, IC, F_ERR, 0, "c_set_err");
        step(1);
        s_c = 1; r_c = 1; q_c = 1; qb_c = 1;     // NOR forbidden expects 00
        ex(1, IC, F_ERR, 1, "c_forb_err"); ex(1, IC, F_ERRCNT, 1, "c_forb_errcnt");
        ex(1, IC, F_FORB, 1, "c_forb_cnt"); ex(1, IC, F_EXPV, 0, "c_forb_expv");
        ex(1, IC, F_STICKY, 1, "c_forb_sticky");
`ifdef SR_CHK_ERR_CAPTURE_EN
        ex(1, IC, F_CAPV, 1, "c_cap_valid"); ex(1, IC, F_CAPP, 3, "c_cap_pair");
        ex(1, IC, F_CAPQ, 3, "c_cap_q"); ex(1, IC, F_CAPS, 3, "c_cap_state");
`endif
        step(1);
        s_c = 1; r_c = 0; q_c = 0; qb_c = 1;     // Q1 with wrong outputs
        ex(1, IC, F_ERR, 1, "c_mis2_err"); ex(1, IC, F_ERRCNT, 2, "c_mis2_errcnt");
        ex(1, IC, F_SET, 2, "c_mis2_set"); ex(1, IC, F_RACE, 0, "c_mis2_race");
`ifdef SR_CHK_ERR_CAPTURE_EN
        ex(1, IC, F_CAPP, 3, "c_cap_keep_pair"); ex(1, IC, F_CAPQ, 3, "c_cap_keep_q");
        ex(1, IC, F_CAPS, 3, "c_cap_keep_state");
`endif
        step(1);
        q_c = 1; qb_c = 0;
        ex(1, IC, F_ERR, 0, "c_ok_err"); ex(1, IC, F_ERRCNT, 2, "c_ok_errcnt");
        step(1);
        clr_c = 1;
        ex(1, IC, F_STICKY, 0, "c_clr_sticky"); ex(1, IC, F_ERRCNT, 0, "c_clr_errcnt");
        ex(1, IC, F_EXPQ, 1, "c_clr_expq");
`ifdef SR_CHK_ERR_CAPTURE_EN
        ex(1, IC, F_CAPV, 0, "c_clr_capv"); ex(1, IC, F_CAPP, 0, "c_clr_capp");
`endif
        step(1);
        clr_c = 0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
        if (sb.size() != 0) begin
            failures++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
